reset_domain_sequencer: RTL
===========================

// Module: reset_domain_sequencer
// PURPOSE
//  Releases NUM_DOMAINS downstream reset domains in a fixed order: 0 first, NUM_DOMAINS-1 last.
//  Reset assertion from reset_n is asynchronous. Deassertion is synchronized through a
//  SYNC_STAGES-deep shift register. After that comes a stretch period, then one domain is
//  released at a time, each waiting on a ready handshake.
//  Sits between the SoC reset pin and the core/bus/debug reset domains.
//  Also supports a software-requested full re-sequence.
// PARAMETERS
//  NUM_DOMAINS     4    number of sequenced reset domains (>=1)
//  SYNC_STAGES     3    synchronizer depth for reset deassertion (>=2)
//  STRETCH_CYCLES  16   cycles all domains stay in reset after sync deassert (>=1)
//  ACK_TIMEOUT     255  max cycles to wait for domain_ready[i] before flagging an error (>=1)
// PORTS
//  clock           in   1               single clock for all logic
//  reset_n         in   1               asynchronous, active-low reset
//  domain_ready    in   NUM_DOMAINS     per-domain "out of reset" handshake; already synchronous to clock
//  sw_reset_req    in   1               level request for a full re-sequence
//  domain_reset_n  out  NUM_DOMAINS     per-domain active-low reset; registered
//  sw_reset_ack    out  1               one-cycle pulse when a software re-sequence completes
//  seq_done        out  1               high while every domain is released (state RUN)
//  seq_error       out  1               sticky; high if any domain_ready timed out
//  err_domain      out  clog2(N)        index of the first domain that timed out
// BEHAVIOUR
//  Reset
//   - reset_n low: all flops clear asynchronously, state=HOLD.
//   - Output reset values: domain_reset_n=0, sw_reset_ack=0, seq_done=0, seq_error=0, err_domain=0.
//  Synchronizer
//   - Input is constant 1. Its output rst_sync_n goes high SYNC_STAGES edges after reset_n
//     is first sampled high.
//  FSM
//   HOLD
//    - Stays here while rst_sync_n=0.
//    - Next edge after rst_sync_n=1: go to STRETCH with cnt=0.
//   STRETCH
//    - cnt increments every cycle.
//    - At the edge where cnt==STRETCH_CYCLES-1: domain_reset_n[0] goes to 1, idx=0, tmr=0, go to WAIT.
//   WAIT
//    - tmr increments every cycle.
//    - On an edge with domain_ready[idx]=1, or with tmr==ACK_TIMEOUT:
//      - On timeout only: set seq_error, and latch err_domain=idx if seq_error was 0.
//      - If idx<N-1: domain_reset_n[idx+1] goes to 1 on that same edge, idx++, tmr=0.
//      - Otherwise go to RUN.
//    - A timeout never hangs the sequence.
//   RUN
//    - seq_done=1.
//    - If sw_reset_req=1 and armed=1, on the next edge:
//      - all domain_reset_n go to 0 together
//      - seq_done=0, seq_error=0, err_domain=0, armed=0, swseq=1
//      - state=STRETCH with cnt=0.
//  Released domains stay released (domain_reset_n is sticky 1) until reset_n or a software request.
//  Latency (reset_n rises, domain_ready tied high)
//   - domain k released at edge SYNC_STAGES+STRETCH_CYCLES+1+k.
//   - RUN entered at edge SYNC_STAGES+STRETCH_CYCLES+N+1.
//  Software handshake
//   - On entry to RUN with swseq=1: sw_reset_ack pulses for exactly 1 cycle, and swseq clears.
//   - armed sets on any edge where sw_reset_req=0. It resets to 1.
//   - A request that stays high after ack does not retrigger.
//   - Requests outside RUN are ignored and not queued.
//  Edge cases
//   - domain_ready[j] for a domain still in reset, or for j!=idx, is ignored.
//   - reset_n falling at any point aborts immediately to the reset values.
//   - ready and timeout on the same edge count as ready: no error.
// STRUCTURE
//  Package reset_seq_pkg holds:
//   - state enum {HOLD, STRETCH, WAIT, RUN}
//   - width localparams for cnt, tmr and idx
//  Sub-module reset_sync:
//   - SYNC_STAGES flops, async clear on reset_n, input tied 1.
//   - The only flops in the block not driven by the FSM.
//  Everything else is one FSM plus three counters (cnt, tmr, idx) in the top module.
// TESTING
//  Defaults, ready tied high, release reset_n:
//   - domain_reset_n goes 0001/0011/0111/1111 at edges 20/21/22/23.
//   - seq_done=1 after edge 24.
//  domain_ready[1] held low:
//   - domain 2 released 256 cycles after domain 1 (tmr reaches ACK_TIMEOUT).
//   - seq_error=1, err_domain=1, sequence still completes.
//  In RUN, raise sw_reset_req and hold it:
//   - all domain_reset_n go 0 next edge, then the sequence repeats.
//   - sw_reset_ack pulses once on RUN; no second sequence until req is dropped and raised again.
//  reset_n pulsed low during WAIT at idx=2:
//   - outputs go to 0 asynchronously.
//   - full sequence restarts from HOLD with identical timing.
//  sw_reset_req raised during STRETCH then dropped before RUN: no re-sequence, no ack.
//  Ready and timeout together on one edge: advances, seq_error stays 0.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset domain sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        StHold    = 2'd0,
        StStretch = 2'd1,
        StWait    = 2'd2,
        StRun     = 2'd3
    } seq_state_e;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned range_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_NUM_DOMAINS    = 4;
    localparam int unsigned DEF_SYNC_STAGES    = 3;
    localparam int unsigned DEF_STRETCH_CYCLES = 16;
    localparam int unsigned DEF_ACK_TIMEOUT    = 255;

    // Counter widths for the default configuration; the top recomputes them from its parameters.
    localparam int unsigned CNT_W = range_width(DEF_STRETCH_CYCLES);
    localparam int unsigned TMR_W = range_width(DEF_ACK_TIMEOUT + 1);
    localparam int unsigned IDX_W = range_width(DEF_NUM_DOMAINS);

endpackage

// File: rtl/reset_sync.sv
// Reset deassertion synchronizer: asserts asynchronously, releases after SYNC_STAGES edges.
module reset_sync #(
    parameter int unsigned SYNC_STAGES = 3
) (
    input  logic clock,
    input  logic reset_n,
    output logic rst_sync_n
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift a constant 1 through the chain; cleared at once by reset_n.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_domain_sequencer.sv
// Releases reset domains one at a time in index order after a synchronized, stretched reset.
module reset_domain_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS    = DEF_NUM_DOMAINS,
    parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int unsigned STRETCH_CYCLES = DEF_STRETCH_CYCLES,
    parameter int unsigned ACK_TIMEOUT    = DEF_ACK_TIMEOUT
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic [NUM_DOMAINS-1:0]              domain_ready,
    input  logic                                sw_reset_req,
    output logic [NUM_DOMAINS-1:0]              domain_reset_n,
    output logic                                sw_reset_ack,
    output logic                                seq_done,
    output logic                                seq_error,
    output logic [range_width(NUM_DOMAINS)-1:0] err_domain
);

    localparam int unsigned CntW = range_width(STRETCH_CYCLES);
    localparam int unsigned TmrW = range_width(ACK_TIMEOUT + 1);
    localparam int unsigned IdxW = range_width(NUM_DOMAINS);

    localparam logic [CntW-1:0] CntLast = CntW'(STRETCH_CYCLES - 1);
    localparam logic [TmrW-1:0] TmrLast = TmrW'(ACK_TIMEOUT);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DOMAINS - 1);

    logic rst_sync_n;

    reset_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_reset_sync (
        .clock     (clock),
        .reset_n   (reset_n),
        .rst_sync_n(rst_sync_n)
    );

    seq_state_e             state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [TmrW-1:0]        tmr_q, tmr_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic [IdxW-1:0]        err_dom_q, err_dom_d;
    logic                   err_q, err_d;
    logic                   armed_q, armed_d;
    logic                   swseq_q, swseq_d;
    logic                   ack_q, ack_d;
    logic                   cur_ready;
    logic                   timeout;

    assign cur_ready = domain_ready[idx_q];
    assign timeout   = (tmr_q == TmrLast);

    // State and counter registers; armed comes out of reset set so the first request is honoured.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StHold;
            cnt_q     <= '0;
            tmr_q     <= '0;
            idx_q     <= '0;
            dom_q     <= '0;
            err_dom_q <= '0;
            err_q     <= 1'b0;
            armed_q   <= 1'b1;
            swseq_q   <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            idx_q     <= idx_d;
            dom_q     <= dom_d;
            err_dom_q <= err_dom_d;
            err_q     <= err_d;
            armed_q   <= armed_d;
            swseq_q   <= swseq_d;
            ack_q     <= ack_d;
        end
    end

    // Next-state logic: hold, stretch, per-domain handshake wait, then run.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmr_d     = tmr_q;
        idx_d     = idx_q;
        dom_d     = dom_q;
        err_dom_d = err_dom_q;
        err_d     = err_q;
        armed_d   = armed_q | ~sw_reset_req;
        swseq_d   = swseq_q;
        ack_d     = 1'b0;

        unique case (state_q)
            StHold: begin
                if (rst_sync_n) begin
                    state_d = StStretch;
                    cnt_d   = '0;
                end
            end
            StStretch: begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    dom_d[0] = 1'b1;
                    idx_d    = '0;
                    tmr_d    = '0;
                    state_d  = StWait;
                end
            end
            StWait: begin
                tmr_d = tmr_q + TmrW'(1);
                if (cur_ready || timeout) begin
                    // Ready wins over a coincident timeout.
                    if (!cur_ready) begin
                        err_d = 1'b1;
                        if (!err_q) begin
                            err_dom_d = idx_q;
                        end
                    end
                    if (idx_q != IdxLast) begin
                        dom_d = dom_q | (NUM_DOMAINS'(2) << idx_q);
                        idx_d = idx_q + IdxW'(1);
                        tmr_d = '0;
                    end else begin
                        state_d = StRun;
                        if (swseq_q) begin
                            ack_d   = 1'b1;
                            swseq_d = 1'b0;
                        end
                    end
                end
            end
            StRun: begin
                if (sw_reset_req && armed_q) begin
                    dom_d     = '0;
                    err_d     = 1'b0;
                    err_dom_d = '0;
                    armed_d   = 1'b0;
                    swseq_d   = 1'b1;
                    cnt_d     = '0;
                    state_d   = StStretch;
                end
            end
            default: begin
                state_d = StHold;
            end
        endcase
    end

    assign domain_reset_n = dom_q;
    assign sw_reset_ack   = ack_q;
    assign seq_done       = (state_q == StRun);
    assign seq_error      = err_q;
    assign err_domain     = err_dom_q;

endmodule
